// File: rtl/xbar_stream.sv
// xbar_stream: configurable NUM_IN -> NUM_OUT lane crossbar for a fixed-length
// stream of beats. One configuration (select/enable/length) is latched, then
// len beats are routed through a single registered output stage with
// valid/ready handshaking on both sides.

// Per-output lane mux: picks the selected input lane, or zero when the lane
// is disabled or the select points past the last input.
module xbar_lane #(
  parameter int DATA_TYPE = 16,
  parameter int NUM_IN    = 16,
  parameter int LOG2_IN   = 4
) (
  input  logic [LOG2_IN-1:0]                sel,
  input  logic                              en,
  input  logic [NUM_IN-1:0][DATA_TYPE-1:0]  lanes,
  output logic [DATA_TYPE-1:0]              dout
);

  // One-hot compare against every input index; out-of-range selects match none.
  always_comb begin
    dout = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (en && int'(sel) == i) dout = lanes[i];
  end

endmodule

module xbar_stream #(
  parameter int DATA_TYPE = 16,
  parameter int NUM_IN    = 16,
  parameter int NUM_OUT   = 16,
  parameter int LOG2_IN   = 4,
  parameter int LEN_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_cfg_valid,
  output logic                          o_cfg_ready,
  input  logic [LOG2_IN*NUM_OUT-1:0]    i_cfg_sel,
  input  logic [NUM_OUT-1:0]            i_cfg_en,
  input  logic [LEN_W-1:0]              i_cfg_len,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [NUM_IN*DATA_TYPE-1:0]   i_data_bus,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [NUM_OUT*DATA_TYPE-1:0]  o_dist_bus,
  output logic [NUM_OUT-1:0]            o_dist_en,
  output logic                          o_last,
  output logic                          o_err
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t                                state;
  logic [NUM_OUT-1:0][LOG2_IN-1:0]       cfg_sel;
  logic [NUM_OUT-1:0]                    cfg_en;
  logic [LEN_W-1:0]                      beats_left;

  logic [NUM_OUT-1:0][LOG2_IN-1:0]       sel_in;
  logic [NUM_IN-1:0][DATA_TYPE-1:0]      lanes_in;
  logic [NUM_OUT-1:0][DATA_TYPE-1:0]     routed;
  logic                                  cfg_bad;
  logic                                  accept;
  logic                                  last_beat;

  assign sel_in   = i_cfg_sel;
  assign lanes_in = i_data_bus;

  assign o_cfg_ready = (state == IDLE);
  // Skid-free single stage: take a new beat when the register is empty or
  // is being emptied this cycle.
  assign o_ready   = (state == STREAM) && (!o_valid || i_ready);
  assign accept    = i_valid && o_ready;
  assign last_beat = (beats_left == LEN_W'(1));

  genvar j;
  generate
    for (j = 0; j < NUM_OUT; j++) begin : g_lane
      xbar_lane #(
        .DATA_TYPE (DATA_TYPE),
        .NUM_IN    (NUM_IN),
        .LOG2_IN   (LOG2_IN)
      ) u_lane (
        .sel   (cfg_sel[j]),
        .en    (cfg_en[j]),
        .lanes (lanes_in),
        .dout  (routed[j])
      );
    end
  endgenerate

  // Flag any enabled output whose incoming select has no matching input lane.
  always_comb begin
    cfg_bad = 1'b0;
    for (int k = 0; k < NUM_OUT; k++)
      if (i_cfg_en[k] && int'(sel_in[k]) >= NUM_IN) cfg_bad = 1'b1;
  end

  // Control FSM plus the registered output stage it owns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cfg_sel    <= '0;
      cfg_en     <= '0;
      beats_left <= '0;
      o_valid    <= 1'b0;
      o_last     <= 1'b0;
      o_err      <= 1'b0;
      o_dist_bus <= '0;
      o_dist_en  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_cfg_valid) begin
            cfg_sel    <= sel_in;
            cfg_en     <= i_cfg_en;
            // A zero length still carries one beat so the stream always ends on o_last.
            beats_left <= (i_cfg_len == '0) ? LEN_W'(1) : i_cfg_len;
            o_err      <= cfg_bad;
            state      <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            o_valid    <= 1'b1;
            o_dist_bus <= routed;
            o_dist_en  <= cfg_en;
            o_last     <= last_beat;
            beats_left <= beats_left - LEN_W'(1);
            if (last_beat) state <= DRAIN;
          end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (o_valid && i_ready) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xbar_stream.sv
// Bench for xbar_stream: table of configurations streamed through a
// scoreboard, plus hand sequences for backpressure and mid-stream reset.
module tb_xbar_stream;

  localparam int DW = 16;
  localparam int NI = 12;
  localparam int NO = 16;
  localparam int LG = 4;
  localparam int LW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_cfg_valid;
  logic              o_cfg_ready;
  logic [LG*NO-1:0]  i_cfg_sel;
  logic [NO-1:0]     i_cfg_en;
  logic [LW-1:0]     i_cfg_len;
  logic              i_valid;
  logic              o_ready;
  logic [NI*DW-1:0]  i_data_bus;
  logic              o_valid;
  logic              i_ready;
  logic [NO*DW-1:0]  o_dist_bus;
  logic [NO-1:0]     o_dist_en;
  logic              o_last;
  logic              o_err;

  xbar_stream #(
    .DATA_TYPE (DW),
    .NUM_IN    (NI),
    .NUM_OUT   (NO),
    .LOG2_IN   (LG),
    .LEN_W     (LW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .i_cfg_sel   (i_cfg_sel),
    .i_cfg_en    (i_cfg_en),
    .i_cfg_len   (i_cfg_len),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data_bus  (i_data_bus),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_dist_bus  (o_dist_bus),
    .o_dist_en   (o_dist_en),
    .o_last      (o_last),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LG*NO-1:0] sel;
    logic [NO-1:0]    en;
    logic [LW-1:0]    len;
    logic             exp_err;
    int               exp_beats;
    logic [31:0]      stall;
    bit               beef;
  } vec_t;

  typedef struct packed {
    logic [NO*DW-1:0] bus;
    logic [NO-1:0]    en;
    logic             last;
  } beat_t;

  localparam int NV = 8;
  vec_t  vt [NV];
  beat_t sbq [$];
  beat_t mon_b;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;

  // Reference model state for the active configuration.
  logic [LG*NO-1:0] m_sel;
  logic [NO-1:0]    m_en;
  int               m_left;

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [NO*DW-1:0] route(logic [NI*DW-1:0] d);
    logic [NO*DW-1:0] r;
    int s;
    r = '0;
    for (int j = 0; j < NO; j++) begin
      s = int'(m_sel[j*LG +: LG]);
      if (m_en[j] && s < NI) r[j*DW +: DW] = d[s*DW +: DW];
    end
    return r;
  endfunction

  function automatic logic [LG*NO-1:0] sel_rot(int off);
    logic [LG*NO-1:0] s;
    for (int j = 0; j < NO; j++) s[j*LG +: LG] = LG'((j + off) % NI);
    return s;
  endfunction

  function automatic logic [NI*DW-1:0] rand_bus(bit beef);
    logic [NI*DW-1:0] r;
    for (int k = 0; k < NI; k++) r[k*DW +: DW] = DW'($urandom);
    if (beef) r[3*DW +: DW] = 16'hBEEF;
    return r;
  endfunction

  // Scoreboard: push model result on each accept, pop and compare on each
  // output transfer.
  always @(negedge clk) begin
    if (rst) begin
      if (o_valid && i_ready) begin
        chk("sb_pending", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          mon_b = sbq.pop_front();
          chk("lane_bus", o_dist_bus, mon_b.bus);
          chk("lane_en", o_dist_en, mon_b.en);
          chk("last", o_last, mon_b.last);
          n_out++;
        end
      end
      if (i_valid && o_ready) begin
        chk("accept_in_budget", m_left > 0, 1);
        if (m_left > 0) begin
          m_left--;
          sbq.push_back('{route(i_data_bus), m_en, m_left == 0});
        end
      end
    end
  end

  task automatic do_cfg(logic [LG*NO-1:0] sel, logic [NO-1:0] en, logic [LW-1:0] len);
    int t;
    t = 0;
    i_cfg_sel = sel; i_cfg_en = en; i_cfg_len = len; i_cfg_valid = 1'b1;
    i_valid = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    while (!o_cfg_ready && t < 50) begin @(negedge clk); t++; end
    chk("cfg_ready", o_cfg_ready, 1);
    chk("idle_no_ready", o_ready, 0);
    m_sel = sel; m_en = en; m_left = (len == 0) ? 1 : int'(len);
    @(posedge clk); #1;
    i_cfg_valid = 1'b0;
  endtask

  task automatic run_stream(int offer, logic [31:0] stall, bit beef,
                            output int sent, output int cyc);
    sent = 0; cyc = 0;
    while (!(o_cfg_ready && !o_valid) && cyc < 1000) begin
      i_valid    = (sent < offer);
      i_data_bus = rand_bus(beef);
      i_ready    = !stall[cyc % 32];
      @(negedge clk);
      if (i_valid && o_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("stream_done", cyc < 1000, 1);
    chk("sb_empty", sbq.size(), 0);
    i_valid = 1'b0; i_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s, c, o0;
    logic [LG*NO-1:0] bad_sel;
    logic [NI*DW-1:0] d1;
    logic [NO*DW-1:0] hold;

    vt[0] = '{sel_rot(0), 16'hFFFF, 8'd4, 1'b0, 4, 32'h0, 1'b0};
    vt[1] = '{{NO{4'd3}}, 16'h00FF, 8'd2, 1'b0, 2, 32'h0, 1'b1};
    vt[2] = '{sel_rot(1), 16'hFFFF, 8'd5, 1'b0, 5, 32'h0000_000E, 1'b0};
    vt[3] = '{sel_rot(0), 16'hFFFF, 8'd3, 1'b1, 3, 32'h0000_00A5, 1'b0};
    vt[3].sel[3:0] = 4'd13;
    vt[4] = '{sel_rot(7), 16'hF0F0, 8'd3, 1'b0, 3, 32'h0, 1'b0};
    vt[5] = '{sel_rot(2), 16'hFFFF, 8'd0, 1'b0, 1, 32'h0, 1'b0};
    vt[6] = '{sel_rot(4), 16'h5A5A, 8'd20, 1'b0, 20, 32'h1234_5678, 1'b0};
    vt[7] = '{sel_rot(5), 16'h7FFF, 8'd2, 1'b0, 2, 32'h0, 1'b0};
    vt[7].sel[15*LG +: LG] = 4'd15;

    rst = 1'b0; i_cfg_valid = 1'b0; i_cfg_sel = '0; i_cfg_en = '0; i_cfg_len = '0;
    i_valid = 1'b0; i_data_bus = '0; i_ready = 1'b1; m_sel = '0; m_en = '0; m_left = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_last", o_last, 0);
    chk("rst_err", o_err, 0);
    chk("rst_bus", o_dist_bus, 0);
    chk("rst_en", o_dist_en, 0);
    chk("rst_ready", o_ready, 0);
    @(posedge clk); #1 rst = 1'b1;

    for (int v = 0; v < NV; v++) begin
      do_cfg(vt[v].sel, vt[v].en, vt[v].len);
      chk("err_on_cfg", o_err, vt[v].exp_err);
      o0 = n_out;
      run_stream(vt[v].exp_beats + 2, vt[v].stall, vt[v].beef, s, c);
      chk("accepted", s, vt[v].exp_beats);
      chk("delivered", n_out - o0, vt[v].exp_beats);
      chk("err_sticky", o_err, vt[v].exp_err);
      if (vt[v].stall == 0) chk("cycles", c, vt[v].exp_beats + 1);
    end

    // Backpressure: one beat parked in the output register for three cycles.
    do_cfg(sel_rot(3), 16'hFFFF, 8'd3);
    i_ready = 1'b0; i_valid = 1'b1; d1 = rand_bus(1'b0); i_data_bus = d1;
    hold = route(d1);
    @(negedge clk);
    chk("pre_valid", o_valid, 0);
    o0 = n_out;
    @(posedge clk); #1;
    i_data_bus = rand_bus(1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", o_valid, 1);
      chk("bp_ready", o_ready, 0);
      chk("bp_bus", o_dist_bus, hold);
      chk("bp_last", o_last, 0);
      @(posedge clk); #1;
    end
    run_stream(5, 32'h0, 1'b0, s, c);
    chk("bp_rest_accepted", s, 2);
    chk("bp_delivered", n_out - o0, 3);

    // Reset while a beat is held in STREAM.
    bad_sel = sel_rot(0);
    bad_sel[3:0] = 4'd13;
    do_cfg(bad_sel, 16'hFFFF, 8'd4);
    chk("pre_rst_err", o_err, 1);
    i_ready = 1'b0; i_valid = 1'b1; i_data_bus = rand_bus(1'b0);
    @(posedge clk); #1;
    chk("pre_rst_valid", o_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", o_valid, 0);
    chk("async_last", o_last, 0);
    chk("async_err", o_err, 0);
    chk("async_bus", o_dist_bus, 0);
    chk("async_en", o_dist_en, 0);
    sbq.delete(); m_left = 0; i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_cfg_ready", o_cfg_ready, 1);
    chk("post_rst_ready", o_ready, 0);
    @(posedge clk); #1;
    do_cfg(sel_rot(0), 16'hFFFF, 8'd2);
    o0 = n_out;
    run_stream(4, 32'h0, 1'b0, s, c);
    chk("post_rst_accepted", s, 2);
    chk("post_rst_delivered", n_out - o0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
